// File: rtl/uart_prog_loader.sv
// UART program loader: packs a length-prefixed byte stream into
// little-endian 32-bit words and writes them to RAM while holding the CPU.
module uart_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rxdata,
    input  logic        rxready,
    input  logic        ram_busy,
    output logic        mem_enable,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA,
        S_WRITE, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [23:0] pack_q;
    logic [1:0]  bcnt_q;
    logic [7:0]  hold_q;
    logic        hold_v_q;

    logic [15:0] len_d;
    logic [15:0] idx_d;
    logic [31:0] addr_d;
    logic        overrun;
    logic        last_word;

    always_comb begin
        len_d     = {rxdata, len_q[7:0]};
        idx_d     = idx_q + 16'd1;
        addr_d    = BASE_ADDR + {14'd0, idx_q, 2'b00};
        overrun   = rxready && hold_v_q;
        last_word = (idx_d == len_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            pack_q     <= '0;
            bcnt_q     <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            mem_enable <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_data   <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
        end else begin
            mem_wen <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    // a byte strobed together with start is dropped
                    if (start) begin
                        state_q    <= S_HDR0;
                        mem_enable <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        idx_q      <= '0;
                        words_done <= '0;
                        bcnt_q     <= '0;
                        hold_v_q   <= 1'b0;
                    end
                end
                S_HDR0: begin
                    if (rxready) begin
                        len_q[7:0] <= rxdata;
                        state_q    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (rxready) begin
                        len_q[15:8] <= rxdata;
                        bcnt_q      <= '0;
                        if (len_d == 16'd0) begin
                            state_q    <= S_DONE;
                            done       <= 1'b1;
                            mem_enable <= 1'b0;
                            cpu_hold   <= 1'b0;
                        end else if (32'(len_d) > MAX_WORDS) begin
                            state_q    <= S_ERR;
                            error      <= 1'b1;
                            mem_enable <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rxready) begin
                        if (bcnt_q == 2'd3) begin
                            mem_data <= {rxdata, pack_q};
                            mem_addr <= addr_d;
                            bcnt_q   <= '0;
                            state_q  <= S_WRITE;
                        end else begin
                            pack_q[{bcnt_q, 3'b000} +: 8] <= rxdata;
                            bcnt_q <= bcnt_q + 2'd1;
                        end
                    end
                end
                S_WRITE, S_WAIT: begin
                    if (overrun) begin
                        state_q    <= S_ERR;
                        error      <= 1'b1;
                        mem_enable <= 1'b0;
                    end else begin
                        if (rxready) begin
                            hold_q   <= rxdata;
                            hold_v_q <= 1'b1;
                        end
                        if (state_q == S_WRITE) begin
                            if (!ram_busy) begin
                                mem_wen <= 1'b1;
                                state_q <= S_WAIT;
                            end
                        end else if (!mem_wen && !ram_busy) begin
                            idx_q      <= idx_d;
                            words_done <= words_done + 16'd1;
                            hold_v_q   <= 1'b0;
                            if (last_word) begin
                                state_q    <= S_DONE;
                                done       <= 1'b1;
                                mem_enable <= 1'b0;
                                cpu_hold   <= 1'b0;
                            end else begin
                                state_q <= S_DATA;
                                // a pending byte becomes byte 0 of the next word
                                if (hold_v_q) begin
                                    pack_q[7:0] <= hold_q;
                                    bcnt_q      <= 2'd1;
                                end else if (rxready) begin
                                    pack_q[7:0] <= rxdata;
                                    bcnt_q      <= 2'd1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a stream-level model predicts the RAM writes
// and end state; two instances cover the normal and the wrapping base address.
module tb_uart_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rxdata = 8'h00;
    logic        rxready = 1'b0;
    logic        ram_busy = 1'b0;

    logic        en0, wen0, hold0, done0, err0;
    logic [31:0] addr0, data0;
    logic [15:0] wd0;
    logic        en1, wen1, hold1, done1, err1;
    logic [31:0] addr1, data1;
    logic [15:0] wd1;

    uart_prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) u0 (
        .clk(clk), .reset(reset), .start(start), .rxdata(rxdata),
        .rxready(rxready), .ram_busy(ram_busy), .mem_enable(en0),
        .mem_wen(wen0), .mem_addr(addr0), .mem_data(data0),
        .cpu_hold(hold0), .done(done0), .error(err0), .words_done(wd0)
    );

    uart_prog_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(256)) u1 (
        .clk(clk), .reset(reset), .start(start), .rxdata(rxdata),
        .rxready(rxready), .ram_busy(ram_busy), .mem_enable(en1),
        .mem_wen(wen1), .mem_addr(addr1), .mem_data(data1),
        .cpu_hold(hold1), .done(done1), .error(err1), .words_done(wd1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] log0[$];
    logic [63:0] log1[$];

    // stream model
    bit          m_act = 1'b0;
    int          m_hc = 0;
    int          m_nb = 0;
    int          m_idx = 0;
    logic [15:0] m_len = '0;
    logic [31:0] m_word = '0;
    bit          exp_done = 1'b0;
    bit          exp_err = 1'b0;
    int          exp_words = 0;

    logic pb = 1'b0;
    logic pw0 = 1'b0;
    logic pw1 = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        m_act = 1'b1; m_hc = 0; m_nb = 0; m_idx = 0;
        exp_done = 1'b0; exp_err = 1'b0; exp_words = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (!m_act) return;
        if (m_hc < 2) begin
            m_len[8*m_hc +: 8] = b;
            m_hc++;
            if (m_hc == 2) begin
                if (m_len == 0) begin
                    exp_done = 1'b1; m_act = 1'b0;
                end else if (m_len > 256) begin
                    exp_err = 1'b1; m_act = 1'b0;
                end
            end
        end else begin
            m_word[8*m_nb +: 8] = b;
            m_nb++;
            if (m_nb == 4) begin
                q0.push_back({32'(m_idx * 4), m_word});
                q1.push_back({32'hFFFF_FFFC + 32'(m_idx * 4), m_word});
                m_idx++;
                m_nb = 0;
                exp_words = m_idx;
                if (m_idx == int'(m_len)) begin
                    exp_done = 1'b1; m_act = 1'b0;
                end
            end
        end
    endtask

    task automatic do_start(input bit with_byte, input logic [7:0] b);
        start = 1'b1; rxready = with_byte; rxdata = b;
        m_start();
        tick();
        start = 1'b0; rxready = 1'b0;
        log0.delete(); log1.delete();
    endtask

    task automatic send(input logic [7:0] b);
        rxdata = b; rxready = 1'b1;
        m_byte(b);
        tick();
        rxready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
        repeat (gap) tick();
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done0 || err0) && n < 200) begin
            tick();
            n++;
        end
        check("end_timeout", {31'd0, done0 | err0}, 32'd1);
    endtask

    task automatic end_checks(input string nm, input bit chk_words);
        check({nm, "_done0"}, {31'd0, done0}, {31'd0, exp_done});
        check({nm, "_err0"}, {31'd0, err0}, {31'd0, exp_err});
        check({nm, "_done1"}, {31'd0, done1}, {31'd0, exp_done});
        check({nm, "_err1"}, {31'd0, err1}, {31'd0, exp_err});
        check({nm, "_hold0"}, {31'd0, hold0}, {31'd0, exp_err});
        check({nm, "_en0"}, {31'd0, en0}, 32'd0);
        if (chk_words) begin
            check({nm, "_words0"}, {16'd0, wd0}, 32'(exp_words));
            check({nm, "_words1"}, {16'd0, wd1}, 32'(exp_words));
        end
        check({nm, "_q0_left"}, 32'(q0.size()), 32'd0);
        check({nm, "_q1_left"}, 32'(q1.size()), 32'd0);
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_ctl0"}, {26'd0, en0, wen0, hold0, done0, err0, 1'b0}, 32'd0);
        check({nm, "_ctl1"}, {26'd0, en1, wen1, hold1, done1, err1, 1'b0}, 32'd0);
        check({nm, "_wd0"}, {16'd0, wd0}, 32'd0);
        check({nm, "_addr0"}, addr0, 32'h0000_0000);
        check({nm, "_addr1"}, addr1, 32'hFFFF_FFFC);
        check({nm, "_data0"}, data0, 32'd0);
    endtask

    // per-cycle write checker for both instances
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wen0) begin
                    if (q0.size() == 0) begin
                        check("u0_spurious_wr", {31'd0, wen0}, 32'd0);
                    end else begin
                        e = q0.pop_front();
                        check("u0_addr", addr0, e[63:32]);
                        check("u0_data", data0, e[31:0]);
                    end
                    check("u0_wen_busy", {31'd0, pb}, 32'd0);
                    check("u0_wen_pulse", {31'd0, pw0}, 32'd0);
                    log0.push_back({addr0, data0});
                end
                if (wen1) begin
                    if (q1.size() == 0) begin
                        check("u1_spurious_wr", {31'd0, wen1}, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        check("u1_addr", addr1, e[63:32]);
                        check("u1_data", data1, e[31:0]);
                    end
                    log1.push_back({addr1, data1});
                end
                if (done0) check("done_state", {30'd0, hold0, en0}, 32'd0);
                if (err0) check("err_state", {30'd0, hold0, en0}, 32'd2);
            end
            pb = ram_busy;
            pw0 = wen0;
            pw1 = wen1;
        end
    end

    initial begin
        repeat (2) tick();
        check_reset("rst");
        reset = 1'b0;
        tick();

        // 1: single word
        do_start(1'b0, 8'h00);
        check("t1_en", {31'd0, en0}, 32'd1);
        check("t1_hold", {31'd0, hold0}, 32'd1);
        send(8'h01); send(8'h00);
        send_word(32'hDEAD_BEEF, 0);
        wait_end();
        end_checks("t1", 1'b1);
        check("t1_nwr", 32'(log0.size()), 32'd1);
        check("t1_lit_addr", log0[0][63:32], 32'h0000_0000);
        check("t1_lit_data", log0[0][31:0], 32'hDEAD_BEEF);
        check("t1_lit_addr1", log1[0][63:32], 32'hFFFF_FFFC);
        check("t1_lit_wd", {16'd0, wd0}, 32'd1);

        // 2: three words, busy stall on the second; start byte dropped
        do_start(1'b1, 8'hAA);
        send(8'h03); send(8'h00);
        send_word(32'h1122_3344, 4);
        send(8'h0D); send(8'hF0); send(8'hFE);
        ram_busy = 1'b1;
        send(8'hCA);
        repeat (5) tick();
        ram_busy = 1'b0;
        repeat (4) tick();
        send_word(32'h5566_7788, 0);
        wait_end();
        end_checks("t2", 1'b1);
        check("t2_addr1", log0[1][63:32], 32'h0000_0004);
        check("t2_data1", log0[1][31:0], 32'hCAFE_F00D);
        check("t2_addr2", log0[2][63:32], 32'h0000_0008);

        // 3: oversized header
        do_start(1'b0, 8'h00);
        send(8'h01); send(8'h02);
        wait_end();
        end_checks("t3", 1'b1);
        check("t3_nwr", 32'(log0.size()), 32'd0);
        do_start(1'b0, 8'h00);
        check("t3_restart_err", {31'd0, err0}, 32'd0);
        check("t3_restart_en", {31'd0, en0}, 32'd1);

        // 6a: empty image
        send(8'h00); send(8'h00);
        wait_end();
        end_checks("t6a", 1'b1);
        check("t6a_nwr", 32'(log0.size()), 32'd0);

        // 4a: one byte arriving during write is kept
        do_start(1'b0, 8'h00);
        send(8'h02); send(8'h00);
        send_word(32'h4433_2211, 0);
        send(8'h55);
        repeat (4) tick();
        send(8'h66); send(8'h77); send(8'h88);
        wait_end();
        end_checks("t4a", 1'b1);
        check("t4a_data1", log0[1][31:0], 32'h8877_6655);

        // 4b: two bytes during write overrun the hold register
        do_start(1'b0, 8'h00);
        send(8'h02); send(8'h00);
        send_word(32'h0A0B_0C0D, 0);
        send(8'hE1); send(8'hE2);
        m_act = 1'b0; exp_err = 1'b1; exp_done = 1'b0;
        repeat (3) tick();
        wait_end();
        end_checks("t4b", 1'b0);

        // 5: reset mid-load, then reload from base
        do_start(1'b0, 8'h00);
        send(8'h03); send(8'h00);
        send_word(32'hA1A2_A3A4, 4);
        send_word(32'hB1B2_B3B4, 4);
        check("t5_wd_before", {16'd0, wd0}, 32'd2);
        reset = 1'b1;
        m_act = 1'b0;
        tick();
        check_reset("t5");
        reset = 1'b0;
        tick();
        do_start(1'b0, 8'h00);
        send(8'h01); send(8'h00);
        send_word(32'hC1C2_C3C4, 0);
        wait_end();
        end_checks("t5", 1'b1);
        check("t5_addr", log0[0][63:32], 32'h0000_0000);
        check("t5_data", log0[0][31:0], 32'hC1C2_C3C4);

        // 6b: address wrap on the high-base instance
        do_start(1'b0, 8'h00);
        send(8'h02); send(8'h00);
        send_word(32'h0102_0304, 4);
        send_word(32'h0506_0708, 0);
        wait_end();
        end_checks("t6b", 1'b1);
        check("t6b_u1_a0", log1[0][63:32], 32'hFFFF_FFFC);
        check("t6b_u1_a1", log1[1][63:32], 32'h0000_0000);
        check("t6b_u0_a1", log0[1][63:32], 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
